// File: rtl/nmea_pkg.sv
// nmea_pkg
// Shared definitions for the NMEA-0183 stream receiver: the framing
// characters, the UART and framer state encodings, bit positions inside
// the end-of-sentence status byte, the FIFO entry layout and a hex-digit
// decoder for the checksum field.
package nmea_pkg;

  // Characters the framer reacts to
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  // Bit positions inside the status byte of an end-of-sentence marker
  localparam int ST_CS_OK      = 0;
  localparam int ST_CS_PRESENT = 1;
  localparam int ST_ABORT      = 2;
  localparam int ST_FRAME_ERR  = 3;

  // Entries carry the field index at a fixed width; the top level only
  // exposes the low clog2(MAX_FIELDS) bits, so MAX_FIELDS may be at most 256.
  localparam int FIELD_MAX_W = 8;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    F_HUNT,
    F_BODY,
    F_CS_HI,
    F_CS_LO
  } framer_state_e;

  typedef struct packed {
    logic                   kind;
    logic [7:0]             data;
    logic [FIELD_MAX_W-1:0] field;
  } entry_t;

  // Returns {valid, nibble}; only uppercase hex digits are valid.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, 4'(c - 8'h30)};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, 4'(c - 8'h37)};
    end
    return r;
  endfunction

endpackage

// File: rtl/nmea_stream_rx_uart.sv
// nmea_uart_rx
// Oversampling 8N1 receiver. The serial line is first passed through a
// two-flop synchroniser, then a start bit is confirmed at its centre and
// the eight data bits and the stop bit are sampled CLK_PER_BIT cycles apart.
// Ports:
//   clock, reset (async, active low)
//   rx_in      raw serial line, idle high
//   rx_valid   one-cycle pulse, rx_byte holds the received character
//   rx_byte    last good character
//   frame_err  one-cycle pulse when the stop bit was sampled low
module nmea_uart_rx
  import nmea_pkg::*;
#(
  parameter int CLK_PER_BIT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             half_tick, bit_tick;

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  // State register plus synchroniser and datapath flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= U_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic; a start bit that is no longer low at its centre is
  // treated as a glitch and ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      U_IDLE:  if (!sync2_q) state_d = U_START;
      U_START: if (half_tick) state_d = sync2_q ? U_IDLE : U_DATA;
      U_DATA:  if (bit_tick && bit_idx_q == 3'd7) state_d = U_STOP;
      U_STOP:  if (bit_tick) state_d = U_IDLE;
      default: state_d = U_IDLE;
    endcase
  end

  // Bit counter, shift register and result pulses
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      U_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      U_START: begin
        if (half_tick) cnt_d = '0;
      end
      U_DATA: begin
        if (bit_tick) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      U_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign rx_valid  = valid_q;
  assign rx_byte   = byte_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/nmea_stream_rx.sv
// nmea_stream_rx
// NMEA-0183 receiver producing a tagged, checksum-verified character stream.
// A UART feeds a sentence framer that tracks the field index and XOR
// checksum; data characters and end-of-sentence markers are written into a
// ready/valid FIFO. Sentence outcome counters run alongside.
// Ports:
//   clock, reset (async, active low)
//   inGPS                    raw serial line
//   m_valid/m_ready          FIFO head handshake
//   m_kind/m_byte/m_field    head entry: data char or marker with status
//   frame_err                pulse on a low stop bit
//   overflow                 sticky, an entry was dropped on a full FIFO
//   clr                      clears overflow and both counters
//   good_cnt/bad_cnt         saturating sentence counters
module nmea_stream_rx
  import nmea_pkg::*;
#(
  parameter  int CLK_PER_BIT = 8,
  parameter  int MAX_FIELDS  = 32,
  parameter  int MAX_LEN     = 82,
  parameter  int FIFO_DEPTH  = 16,
  localparam int FIELD_W     = $clog2(MAX_FIELDS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inGPS,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_kind,
  output logic [7:0]         m_byte,
  output logic [FIELD_W-1:0] m_field,
  output logic               frame_err,
  output logic               overflow,
  input  logic               clr,
  output logic [15:0]        good_cnt,
  output logic [15:0]        bad_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(MAX_FIELDS - 1);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  nmea_uart_rx #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_uart (
    .clock     (clock),
    .reset     (reset),
    .rx_in     (inGPS),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_frame_err)
  );

  assign frame_err = rx_frame_err;

  // ---------------------------------------------------------------- framer
  framer_state_e      f_state_q, f_state_d;
  logic [7:0]         xor_q, xor_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               fe_q, fe_d;
  logic [3:0]         hi_q, hi_d;
  logic               cs_bad_q, cs_bad_d;
  logic               push_q, push_d;
  entry_t             push_entry_q, push_entry_d;

  logic       is_dollar, is_star, is_comma, is_eol, len_full, cs_match;
  logic [4:0] hex_nib;

  assign is_dollar = (rx_byte == CH_DOLLAR);
  assign is_star   = (rx_byte == CH_STAR);
  assign is_comma  = (rx_byte == CH_COMMA);
  assign is_eol    = (rx_byte == CH_CR) || (rx_byte == CH_LF);
  assign len_full  = (len_q == LEN_W'(MAX_LEN));
  assign hex_nib   = hex_decode(rx_byte);
  assign cs_match  = hex_nib[4] && !cs_bad_q && ({hi_q, hex_nib[3:0]} == xor_q);

  // Framer state register and sentence context
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_state_q    <= F_HUNT;
      xor_q        <= '0;
      field_q      <= '0;
      len_q        <= '0;
      fe_q         <= 1'b0;
      hi_q         <= '0;
      cs_bad_q     <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
    end else begin
      f_state_q    <= f_state_d;
      xor_q        <= xor_d;
      field_q      <= field_d;
      len_q        <= len_d;
      fe_q         <= fe_d;
      hi_q         <= hi_d;
      cs_bad_q     <= cs_bad_d;
      push_q       <= push_d;
      push_entry_q <= push_entry_d;
    end
  end

  // Framer next state; the length limit wins over every character.
  always_comb begin
    f_state_d = f_state_q;
    if (rx_valid) begin
      unique case (f_state_q)
        F_HUNT: if (is_dollar) f_state_d = F_BODY;
        F_BODY: begin
          if (len_full)       f_state_d = F_HUNT;
          else if (is_dollar) f_state_d = F_BODY;
          else if (is_star)   f_state_d = F_CS_HI;
          else if (is_eol)    f_state_d = F_HUNT;
        end
        F_CS_HI: f_state_d = len_full ? F_HUNT : F_CS_LO;
        F_CS_LO: f_state_d = F_HUNT;
        default: f_state_d = F_HUNT;
      endcase
    end
  end

  // Framer outputs: checksum/field/length bookkeeping and the entry to push.
  // A '$' inside a sentence closes it as aborted and starts a new one.
  always_comb begin
    xor_d        = xor_q;
    field_d      = field_q;
    len_d        = len_q;
    fe_d         = fe_q | rx_frame_err;
    hi_d         = hi_q;
    cs_bad_d     = cs_bad_q;
    push_d       = 1'b0;
    push_entry_d = '0;
    push_entry_d.field = FIELD_MAX_W'(field_q);
    if (rx_valid) begin
      if (f_state_q == F_HUNT) begin
        if (is_dollar) begin
          xor_d   = '0;
          field_d = '0;
          len_d   = LEN_W'(1);
          fe_d    = 1'b0;
        end
      end else if (len_full) begin
        push_d                          = 1'b1;
        push_entry_d.kind               = 1'b1;
        push_entry_d.data[ST_ABORT]     = 1'b1;
        push_entry_d.data[ST_FRAME_ERR] = fe_q;
      end else begin
        len_d = len_q + LEN_W'(1);
        unique case (f_state_q)
          F_BODY: begin
            if (is_dollar) begin
              push_d                          = 1'b1;
              push_entry_d.kind               = 1'b1;
              push_entry_d.data[ST_ABORT]     = 1'b1;
              push_entry_d.data[ST_FRAME_ERR] = fe_q;
              xor_d   = '0;
              field_d = '0;
              len_d   = LEN_W'(1);
              fe_d    = 1'b0;
            end else if (is_star) begin
              xor_d = xor_q;
            end else if (is_comma) begin
              xor_d = xor_q ^ rx_byte;
              if (field_q != FIELD_LAST) field_d = field_q + FIELD_W'(1);
            end else if (is_eol) begin
              push_d                          = 1'b1;
              push_entry_d.kind               = 1'b1;
              push_entry_d.data[ST_FRAME_ERR] = fe_q;
            end else begin
              xor_d             = xor_q ^ rx_byte;
              push_d            = 1'b1;
              push_entry_d.data = rx_byte;
            end
          end
          F_CS_HI: begin
            hi_d     = hex_nib[3:0];
            cs_bad_d = !hex_nib[4];
          end
          F_CS_LO: begin
            push_d                           = 1'b1;
            push_entry_d.kind                = 1'b1;
            push_entry_d.data[ST_CS_OK]      = cs_match;
            push_entry_d.data[ST_CS_PRESENT] = 1'b1;
            push_entry_d.data[ST_FRAME_ERR]  = fe_q;
          end
          default: len_d = len_q;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  entry_t           mem_q [FIFO_DEPTH];
  logic             fifo_full, pop, wr_en;

  assign wr_idx    = wr_ptr_q[PTR_W-1:0];
  assign rd_idx    = rd_ptr_q[PTR_W-1:0];
  assign fifo_full = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
  assign m_valid   = (wr_ptr_q != rd_ptr_q);
  assign pop       = m_valid && m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en     = push_q && (!fifo_full || pop);
  assign wr_ptr_d  = wr_en ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

  // Storage array; contents are only observed through valid entries.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_idx] <= push_entry_q;
  end

  // Head entry is forced to zero while the FIFO is empty.
  always_comb begin
    m_kind  = 1'b0;
    m_byte  = '0;
    m_field = '0;
    if (m_valid) begin
      m_kind  = mem_q[rd_idx].kind;
      m_byte  = mem_q[rd_idx].data;
      m_field = mem_q[rd_idx].field[FIELD_W-1:0];
    end
  end

  // -------------------------------------------------- overflow and counters
  logic        overflow_q, overflow_d;
  logic [15:0] good_q, good_d, bad_q, bad_d;
  logic        marker_seen;

  // Markers are counted at the write attempt, even when the FIFO drops them.
  assign marker_seen = push_q && push_entry_q.kind;

  always_comb begin
    overflow_d = overflow_q;
    good_d     = good_q;
    bad_d      = bad_q;
    if (clr) begin
      overflow_d = 1'b0;
      good_d     = '0;
      bad_d      = '0;
    end else begin
      if (push_q && !wr_en) overflow_d = 1'b1;
      if (marker_seen) begin
        if (push_entry_q.data[ST_CS_OK]) begin
          if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
        end else begin
          if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
        end
      end
    end
  end

  // FIFO pointers, sticky overflow and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign overflow = overflow_q;
  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;

endmodule

// File: doc/nmea_stream_rx.md
# nmea_stream_rx

Parametrised NMEA-0183 receiver that replaces fixed-sentence GPS decoding with a generic, checksum-verified character stream. It contains an oversampling UART and a sentence framer that tracks field indices and XOR checksums. Output goes through a ready/valid FIFO. It sits between the GPS module's serial line and any downstream field decoders, which select sentences and fields from the tagged stream.

## Interface
- CLK_PER_BIT, 8: clock cycles per serial bit; must be ≥4.
- MAX_FIELDS, 32: field index saturates at MAX_FIELDS-1. FIELD_W = clog2(MAX_FIELDS).
- MAX_LEN, 82: maximum characters from '$' up to the checksum, inclusive.
- FIFO_DEPTH, 16: output FIFO entries; must be a power of two.
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- inGPS  in  1  raw serial line, idle high, 8N1, LSB first
- m_valid  out  1  FIFO head entry valid
- m_ready  in  1  consumer accepts head entry
- m_kind  out  1  0 = data character; 1 = end-of-sentence marker
- m_byte  out  8  character (kind 0) or status (kind 1): [0] checksum ok, [1] checksum present, [2] aborted/too long, [3] framing error seen
- m_field  out  FIELD_W  field index of the entry (0 = address field)
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low
- overflow  out  1  sticky: an entry was dropped because the FIFO was full
- clr  in  1  synchronous clear of overflow and both counters
- good_cnt  out  16  sentences ending with checksum ok; saturating
- bad_cnt  out  16  all other end markers; saturating

## Operation
- **Input sync:** inGPS passes through a 2-flop synchroniser.
- **UART states:** IDLE → START → DATA → STOP.
  - IDLE: a low sample enters START.
  - START: at CLK_PER_BIT/2 the line must still be low, otherwise return to IDLE (glitch reject).
  - DATA: 8 bits are sampled, each CLK_PER_BIT cycles apart.
  - STOP: the stop bit is sampled. High → rx_valid pulse with the byte. Low → frame_err pulse, byte discarded, sentence flag fe set.
- **Framer states:** HUNT, BODY, CS_HI, CS_LO.
  - HUNT: only '$' is significant. On '$': xor=0, field=0, len=1, fe=0, go to BODY.
  - BODY, ',': xor ^= byte, field++ (saturating), no push.
  - BODY, '*': go to CS_HI.
  - BODY, CR or LF: push end marker with status {fe,0,0,0}, go to HUNT.
  - BODY, '$': push end marker with bit2 set, then restart the sentence as in HUNT.
  - BODY, any other byte: xor ^= byte, push data entry {0, byte, field}.
  - len counts every accepted byte. A byte arriving when len = MAX_LEN causes an end marker with bit2 set and a return to HUNT.
- **Checksum:**
  - CS_HI and CS_LO accept uppercase hex only ('0'-'9', 'A'-'F').
  - After CS_LO, push end marker with bit1 = 1, bit0 = (rx value == xor) and no non-hex digit, bit3 = fe. Return to HUNT.
  - Trailing CR/LF is ignored in HUNT.
- **Counters:** every end marker updates good_cnt or bad_cnt, even when the marker itself is dropped.
- **FIFO:**
  - A push is accepted if not full, or if full and popped in the same cycle.
  - Otherwise the entry is dropped and overflow is set.
  - Pop occurs when m_valid && m_ready.
- **Priority:** clr has priority over a same-cycle counter increment or overflow set.

## Timing
- inGPS edge → UART sees it: 2 cycles.
- Stop-bit centre sample → rx_valid: 1 cycle.
- rx_valid → FIFO write: 1 cycle.
- Write → m_valid into an empty FIFO: 1 cycle.
- Counters update in the same cycle as the FIFO write of the end marker.
- m_kind, m_byte and m_field hold stable while m_valid && !m_ready.
- Reset values: m_valid 0, m_kind 0, m_byte 0, m_field 0, frame_err 0, overflow 0, good_cnt 0, bad_cnt 0. FIFO empty, UART in IDLE, framer in HUNT.
- Reset asserted mid-byte or mid-sentence aborts immediately. No marker is emitted.
- Throughput: at most one entry per CLK_PER_BIT×10 cycles. The FIFO absorbs consumer stalls.

## Structure
- **nmea_pkg:**
  - character constants: '$', '*', ',', CR, LF
  - UART and framer state enums
  - status bit positions
  - FIFO entry struct {kind, byte, field}
- **Sub-module:** nmea_uart_rx (synchroniser, oversampling receiver, frame_err), parametrised by CLK_PER_BIT.
- **Top level:** framer, counters and FIFO stay in nmea_stream_rx.

## Test plan
1. "$AB*03\r\n", m_ready=1 → entries ('A',f0), ('B',f0), marker 0x03; good_cnt=1.
2. "$A,B*2F" → ('A',f0), ('B',f1), marker 0x03. Then "$A,B*2E" → marker 0x02; bad_cnt=1.
3. "$AB*03" with the stop bit of 'A' driven low → frame_err pulse, only ('B',f0) pushed, marker 0x0A.
4. FIFO_DEPTH=16, m_ready=0, "$ABCDEFGHIJKLMNOPQRST" → 16 entries held, overflow=1. Raising m_ready drains 'A'…'P'; clr → overflow=0.
5. "$AB$AB*03" → 'A','B', marker 0x04, 'A','B', marker 0x03. Also a 3-cycle low glitch on inGPS → no entry.
6. Reset asserted during the 3rd data bit of a sentence → all outputs 0 the next cycle. After release, "$AB*03" parses exactly as in scenario 1.
